// File: rtl/add_word_sequencer_pkg.sv
// Shared constants and types for the multi-word add/subtract sequencer.
//   WORD_W          : width of one datapath word (one adder pass)
//   S_IDLE/RUN/DONE : state encoding constants
//   state_e         : typed FSM state built on those constants
//   idx_width()     : word-index width, never less than one bit
package add_word_sequencer_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StRun  = S_RUN,
    StDone = S_DONE
  } state_e;

  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/full_adder_16bit.sv
// 16-bit full adder shared by the word sequencer.
//   a, b : addends
//   cin  : carry in
//   sum  : low 16 bits of a + b + cin
//   cout : carry out of bit 15
module full_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
  end

endmodule

// File: rtl/add_word_sequencer.sv
// Multi-cycle WORDS x 16-bit add/subtract, one word per clock, LSW first, through a
// single shared 16-bit adder with the carry chained in a register.
//   clk, rst        : clock, synchronous active-high reset
//   start           : request, accepted only while idle
//   op_sub, cin_in  : 0 -> a + b + cin_in, 1 -> a - b
//   op_a, op_b      : operands, captured on the accepting edge
//   busy, done      : busy while not idle; done pulses for one cycle with the result
//   result          : sum/difference
//   carry_out       : final carry (subtract: 1 = no borrow)
//   overflow, zero  : signed overflow of the full-width op, result == 0
module add_word_sequencer
  import add_word_sequencer_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    op_sub,
  input  logic                    cin_in,
  input  logic [WORD_W*WORDS-1:0] op_a,
  input  logic [WORD_W*WORDS-1:0] op_b,
  output logic                    busy,
  output logic                    done,
  output logic [WORD_W*WORDS-1:0] result,
  output logic                    carry_out,
  output logic                    overflow,
  output logic                    zero
);

  localparam int unsigned W    = WORD_W * WORDS;
  localparam int unsigned IdxW = idx_width(WORDS);
  localparam int unsigned SelW = $clog2(W);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d, result_q, result_d;
  logic              sub_q, sub_d, carry_q, carry_d;
  logic              carry_out_q, carry_out_d, overflow_q, overflow_d, zero_q, zero_d;

  logic [SelW-1:0]   base;
  logic [WORD_W-1:0] fa_a, fa_b, fa_sum;
  logic              fa_cout, last_word;

  // Bit offset of the current word inside the operand/result registers.
  assign base      = SelW'(int'(idx_q) * WORD_W);
  assign last_word = (idx_q == IdxW'(WORDS - 1));
  assign fa_a      = a_q[base +: WORD_W];
  assign fa_b      = sub_q ? ~b_q[base +: WORD_W] : b_q[base +: WORD_W];

  full_adder_16bit u_adder (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = op_sub;
          // Subtract is a + ~b + 1, so the +1 enters as the initial carry.
          carry_d = op_sub ? 1'b1 : cin_in;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        result_d[base +: WORD_W] = fa_sum;
        carry_d = fa_cout;
        idx_d   = idx_q + 1'b1;
        if (last_word) begin
          // Flags land on the edge into DONE so they are valid alongside done.
          idx_d       = '0;
          carry_out_d = fa_cout;
          overflow_d  = (fa_a[WORD_W-1] == fa_b[WORD_W-1]) &&
                        (fa_sum[WORD_W-1] != fa_a[WORD_W-1]);
          zero_d      = (result_d == '0);
          state_d     = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_add_word_sequencer.sv
// Self-checking bench for add_word_sequencer (WORDS = 4): directed vector table,
// randomized operations against an arithmetic reference model, and hand-written
// sequences for ignored starts and mid-operation reset.
module tb_add_word_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst, start, op_sub, cin_in;
  logic [W-1:0] op_a, op_b, result;
  logic         busy, done, carry_out, overflow, zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_word_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_sub    (op_sub),
    .cin_in    (cin_in),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] exp_res;
    logic         exp_c;
    logic         exp_v;
    logic         exp_z;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: whole-operand unsigned arithmetic for result/carry, sign-extended
  // arithmetic for overflow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, output logic [W-1:0] r, output logic c,
                       output logic v, output logic z);
    logic [W:0]          u;
    logic signed [W+1:0] s;
    if (sub) begin
      u = {1'b0, a} - {1'b0, b};
      c = ~u[W];  // carry set when no borrow
      s = $signed({a[W-1], a[W-1], a}) - $signed({b[W-1], b[W-1], b});
    end else begin
      u = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      c = u[W];
      s = $signed({a[W-1], a[W-1], a}) + $signed({b[W-1], b[W-1], b})
          + $signed({{(W+1){1'b0}}, cin});
    end
    r = u[W-1:0];
    v = (s[W] != s[W-1]);
    z = (r == '0);
  endtask

  // Issue one op and wait for done; lat = cycles from start edge to done, -1 on timeout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic cin, output int lat, output int busy_cycles);
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub; cin_in = cin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = '1; op_b = '1; op_sub = ~sub; cin_in = ~cin;  // operands are don't-care now
    lat = -1;
    busy_cycles = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      errors++;
      $display("FAIL done_timeout got=none expected=done within 20 cycles");
    end
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin);
    logic [W-1:0] r;
    logic c, v, z;
    int lat, bc;
    model(a, b, sub, cin, r, c, v, z);
    run_op(a, b, sub, cin, lat, bc);
    chk({tag, "_result"}, result, r);
    chk({tag, "_carry"}, W'(carry_out), W'(c));
    chk({tag, "_overflow"}, W'(overflow), W'(v));
    chk({tag, "_zero"}, W'(zero), W'(z));
    chk({tag, "_latency"}, W'(lat), W'(WORDS + 1));
    chk({tag, "_busy_cycles"}, W'(bc), W'(WORDS + 1));
  endtask

  vec_t vecs[7];
  int   lat, bc, dones, first_lat;
  logic [W-1:0] saved;

  initial begin
    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
                64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h1, 1'b0, 1'b0, 1'b0};
    // cin_in must be ignored on subtract
    vecs[6] = '{64'h1234, 64'h1234, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin_in = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_result", result, '0);
    chk("reset_flags", W'({carry_out, overflow, zero}), '0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat, bc);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("vec%0d_carry", i), W'(carry_out), W'(vecs[i].exp_c));
      chk($sformatf("vec%0d_overflow", i), W'(overflow), W'(vecs[i].exp_v));
      chk($sformatf("vec%0d_zero", i), W'(zero), W'(vecs[i].exp_z));
      chk($sformatf("vec%0d_latency", i), W'(lat), 64'd5);
      chk($sformatf("vec%0d_busy_cycles", i), W'(bc), 64'd5);
      @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", i), W'({done, busy}), '0);
    end

    // Result and flags hold in idle.
    saved = result;
    repeat (4) @(negedge clk);
    chk("idle_hold_result", result, saved);
    chk("idle_hold_flags", W'({carry_out, overflow, zero}), W'(3'b101));

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = ~ra;
      if ($urandom_range(0, 3) == 0) ra[W-1] = rb[W-1];
      check_op($sformatf("rand%0d", i), ra, rb, 1'(($urandom & 32'h1)), 1'(($urandom & 32'h1)));
    end

    // Starts during RUN and during DONE must be ignored.
    @(negedge clk);
    op_a = 64'h1234; op_b = 64'h1111; op_sub = 1'b0; cin_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    first_lat = -1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        dones++;
        if (first_lat < 0) first_lat = n;
      end
      if (n == 2 || (done && dones == 1)) begin
        op_a = 64'hDEAD_BEEF; op_b = 64'h5555; op_sub = 1'b1; start = 1'b1;
      end
    end
    chk("ignore_done_count", W'(dones), 64'd1);
    chk("ignore_latency", W'(first_lat), 64'd5);
    chk("ignore_result", result, 64'h2345);
    chk("ignore_busy_after", W'(busy), '0);

    // Leave carry and zero set so the reset check below can see them clear.
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat, bc);
    chk("prereset_flags", W'({carry_out, zero}), W'(2'b11));

    // Reset at the edge after word 2 is written.
    @(negedge clk);
    op_a = 64'h1111_2222_3333_4444; op_b = 64'h1; op_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_result", result, '0);
    chk("abort_flags", W'({carry_out, overflow, zero}), '0);
    dones = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("abort_no_done", W'(dones), '0);
    check_op("post_abort", 64'h1111_2222_3333_4444, 64'h0001_0001_0001_FFFF, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
